// File: rtl/cache_types_pkg.sv
// ---------------------------------------------------------------------------
// cache_types_pkg
// Shared types and constants for the 4-way set-associative cache controller:
//   - controller state encoding
//   - address geometry (line offset width, default set-index width)
//   - way count and PLRU bit layout
//   - pmem_addr_sel / wmask_sel encodings
//   - small helpers for way one-hot and hit priority encoding
// ---------------------------------------------------------------------------
package cache_types_pkg;

  // 32-byte lines: bits [4:0] are the byte offset within a line.
  localparam int S_OFFSET        = 5;
  localparam int S_INDEX_DEFAULT = 4;

  localparam int NUM_WAYS  = 4;
  localparam int WAY_BITS  = 2;
  localparam int PLRU_BITS = 3;

  // Bit positions of {b0,b1,b2} inside a 3-bit PLRU word: b0 is the MSB,
  // so the word reads left to right as {b0,b1,b2}.
  localparam int PLRU_B0 = 2;
  localparam int PLRU_B1 = 1;
  localparam int PLRU_B2 = 0;

  // Line address source for physical memory.
  localparam logic PMEM_SEL_CPU    = 1'b0;
  localparam logic PMEM_SEL_VICTIM = 1'b1;

  // Data array write mask source.
  localparam logic WMASK_FULL_LINE = 1'b0;
  localparam logic WMASK_CPU       = 1'b1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    COMPARE   = 3'd1,
    WRITEBACK = 3'd2,
    ALLOCATE  = 3'd3,
    REREAD    = 3'd4
  } cache_state_t;

  // One-hot select of a single way.
  function automatic logic [NUM_WAYS-1:0] way_onehot(input logic [WAY_BITS-1:0] way);
    logic [NUM_WAYS-1:0] v;
    v      = '0;
    v[way] = 1'b1;
    return v;
  endfunction

  // Index of the lowest set bit. Several hits at once should never happen;
  // if they do, the lowest way is the one served.
  function automatic logic [WAY_BITS-1:0] lowest_hit_way(input logic [NUM_WAYS-1:0] hits);
    logic [WAY_BITS-1:0] w;
    w = '0;
    for (int i = NUM_WAYS - 1; i >= 0; i--) begin
      if (hits[i]) w = WAY_BITS'(i);
    end
    return w;
  endfunction

endpackage

// File: rtl/cache_plru.sv
// ---------------------------------------------------------------------------
// cache_plru
// Tree pseudo-LRU state for every set (3 bits per set, 4 ways), plus the
// replacement choice for the currently addressed set.
//   clk         in   clock, rising edge
//   rst         in   asynchronous active-high reset, clears all PLRU bits
//   index       in   set index of the current request
//   update      in   record an access to access_way in set index
//   access_way  in   way that was just accessed
//   victim_way  out  replacement way for set index (combinational)
// ---------------------------------------------------------------------------
module cache_plru
  import cache_types_pkg::*;
#(
  parameter int s_index = S_INDEX_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [s_index-1:0]  index,
  input  logic                update,
  input  logic [WAY_BITS-1:0] access_way,
  output logic [WAY_BITS-1:0] victim_way
);

  localparam int NUM_SETS = 1 << s_index;

  logic [PLRU_BITS-1:0] plru_reg [NUM_SETS];
  logic [PLRU_BITS-1:0] cur_bits;
  logic [PLRU_BITS-1:0] next_bits;

  assign cur_bits = plru_reg[index];

  // b0 picks the half, then b2 (upper pair) or b1 (lower pair) picks the way.
  always_comb begin
    victim_way = '0;
    if (cur_bits[PLRU_B0]) begin
      victim_way = cur_bits[PLRU_B2] ? 2'd3 : 2'd2;
    end else begin
      victim_way = cur_bits[PLRU_B1] ? 2'd1 : 2'd0;
    end
  end

  // Point the tree away from the way just used.
  always_comb begin
    next_bits = cur_bits;
    if (!access_way[1]) begin
      next_bits[PLRU_B0] = 1'b1;
      next_bits[PLRU_B1] = ~access_way[0];
    end else begin
      next_bits[PLRU_B0] = 1'b0;
      next_bits[PLRU_B2] = ~access_way[0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        plru_reg[s] <= '0;
      end
    end else if (update) begin
      plru_reg[index] <= next_bits;
    end
  end

endmodule

// File: rtl/cache_control.sv
// ---------------------------------------------------------------------------
// cache_control
// Control FSM for a 4-way set-associative, write-back, write-allocate cache.
// Drives the datapath strobes and the physical memory handshake; replacement
// is tree PLRU held in cache_plru.
//   clk, rst                      clock / async active-high reset
//   mem_read, mem_write           CPU request strobes, held until mem_resp
//   mem_address                   CPU byte address (index = [s_index+4:5])
//   mem_resp                      one-cycle request-complete pulse
//   way_hit                       per-way valid&tag-match from the datapath
//   victim_valid, victim_dirty    status of victim_way at the current index
//   victim_way                    PLRU replacement way for the current index
//   data_web                      per-way data write enable, active low
//   wmask_sel                     0 full line from pmem, 1 CPU byte mask
//   tag_load/valid_load/dirty_load per-way metadata load strobes
//   dirty_in                      value written on dirty_load
//   pmem_addr_sel                 0 CPU line address, 1 victim line address
//   pmem_read, pmem_write         memory strobes, held until pmem_resp
//   pmem_resp                     memory completion pulse
// ---------------------------------------------------------------------------
module cache_control
  import cache_types_pkg::*;
#(
  parameter int s_index = S_INDEX_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mem_read,
  input  logic                mem_write,
  input  logic [31:0]         mem_address,
  output logic                mem_resp,
  input  logic [NUM_WAYS-1:0] way_hit,
  input  logic                victim_valid,
  input  logic                victim_dirty,
  output logic [WAY_BITS-1:0] victim_way,
  output logic [NUM_WAYS-1:0] data_web,
  output logic                wmask_sel,
  output logic [NUM_WAYS-1:0] tag_load,
  output logic [NUM_WAYS-1:0] valid_load,
  output logic [NUM_WAYS-1:0] dirty_load,
  output logic                dirty_in,
  output logic                pmem_addr_sel,
  output logic                pmem_read,
  output logic                pmem_write,
  input  logic                pmem_resp
);

  cache_state_t        state_reg;
  cache_state_t        state_next;
  logic [s_index-1:0]  index;
  logic                hit_any;
  logic [WAY_BITS-1:0] hit_way;
  logic                plru_update;
  logic                unused_addr;

  assign index       = mem_address[s_index+S_OFFSET-1:S_OFFSET];
  assign unused_addr = ^{mem_address[31:s_index+S_OFFSET], mem_address[S_OFFSET-1:0]};

  assign hit_any = |way_hit;
  assign hit_way = lowest_hit_way(way_hit);

  cache_plru #(
    .s_index (s_index)
  ) plru_inst (
    .clk        (clk),
    .rst        (rst),
    .index      (index),
    .update     (plru_update),
    .access_way (hit_way),
    .victim_way (victim_way)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // All outputs are decoded from the state; since the state register resets
  // asynchronously, every strobe drops in the same cycle rst rises.
  always_comb begin
    state_next    = state_reg;
    mem_resp      = 1'b0;
    data_web      = '1;
    wmask_sel     = WMASK_FULL_LINE;
    tag_load      = '0;
    valid_load    = '0;
    dirty_load    = '0;
    dirty_in      = 1'b0;
    pmem_addr_sel = PMEM_SEL_CPU;
    pmem_read     = 1'b0;
    pmem_write    = 1'b0;
    plru_update   = 1'b0;

    unique case (state_reg)
      IDLE: begin
        // Tag/valid arrays need one cycle to produce way_hit for this index.
        if (mem_read || mem_write) begin
          state_next = COMPARE;
        end
      end

      COMPARE: begin
        if (hit_any) begin
          mem_resp    = 1'b1;
          plru_update = 1'b1;
          // A simultaneous read and write strobe is served as a write.
          if (mem_write) begin
            data_web   = ~way_onehot(hit_way);
            wmask_sel  = WMASK_CPU;
            dirty_load = way_onehot(hit_way);
            dirty_in   = 1'b1;
          end
          state_next = IDLE;
        end else if (victim_valid && victim_dirty) begin
          state_next = WRITEBACK;
        end else begin
          state_next = ALLOCATE;
        end
      end

      WRITEBACK: begin
        pmem_write    = 1'b1;
        pmem_addr_sel = PMEM_SEL_VICTIM;
        if (pmem_resp) begin
          state_next = ALLOCATE;
        end
      end

      ALLOCATE: begin
        pmem_read     = 1'b1;
        pmem_addr_sel = PMEM_SEL_CPU;
        if (pmem_resp) begin
          // Fill the victim with a clean line; PLRU is left alone here and
          // is updated by the hit that follows in COMPARE.
          data_web   = ~way_onehot(victim_way);
          wmask_sel  = WMASK_FULL_LINE;
          tag_load   = way_onehot(victim_way);
          valid_load = way_onehot(victim_way);
          dirty_load = way_onehot(victim_way);
          dirty_in   = 1'b0;
          state_next = REREAD;
        end
      end

      REREAD: begin
        // Give the arrays a cycle to return the freshly written line.
        state_next = COMPARE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_cache_control.sv
module tb_cache_control;
  import cache_types_pkg::*;

  localparam int MEM_LAT = 3;
  localparam int TXN_BUDGET = 60;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_address;
  logic        mem_resp;
  logic [3:0]  way_hit;
  logic        victim_valid;
  logic        victim_dirty;
  logic [1:0]  victim_way;
  logic [3:0]  data_web;
  logic        wmask_sel;
  logic [3:0]  tag_load;
  logic [3:0]  valid_load;
  logic [3:0]  dirty_load;
  logic        dirty_in;
  logic        pmem_addr_sel;
  logic        pmem_read;
  logic        pmem_write;
  logic        pmem_resp = 1'b0;

  int n_compared = 0;
  int n_mismatched = 0;

  always #5 clk = ~clk;

  cache_control dut (
    .clk           (clk),
    .rst           (rst),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_address   (mem_address),
    .mem_resp      (mem_resp),
    .way_hit       (way_hit),
    .victim_valid  (victim_valid),
    .victim_dirty  (victim_dirty),
    .victim_way    (victim_way),
    .data_web      (data_web),
    .wmask_sel     (wmask_sel),
    .tag_load      (tag_load),
    .valid_load    (valid_load),
    .dirty_load    (dirty_load),
    .dirty_in      (dirty_in),
    .pmem_addr_sel (pmem_addr_sel),
    .pmem_read     (pmem_read),
    .pmem_write    (pmem_write),
    .pmem_resp     (pmem_resp)
  );

  // ---------------- datapath model: tag/valid/dirty arrays ----------------
  logic [22:0] tag_m   [16][4];
  logic        valid_m [16][4];
  logic        dirty_m [16][4];
  logic [3:0]  idx;

  assign idx = mem_address[8:5];

  initial begin
    for (int s = 0; s < 16; s++) begin
      for (int w = 0; w < 4; w++) begin
        tag_m[s][w]   = '0;
        valid_m[s][w] = 1'b0;
        dirty_m[s][w] = 1'b0;
      end
    end
  end

  always_comb begin
    way_hit = '0;
    for (int w = 0; w < 4; w++) begin
      way_hit[w] = valid_m[idx][w] && (tag_m[idx][w] == mem_address[31:9]);
    end
  end

  assign victim_valid = valid_m[idx][victim_way];
  assign victim_dirty = dirty_m[idx][victim_way];

  always @(posedge clk) begin
    for (int w = 0; w < 4; w++) begin
      if (tag_load[w])   tag_m[idx][w]   <= mem_address[31:9];
      if (valid_load[w]) valid_m[idx][w] <= 1'b1;
      if (dirty_load[w]) dirty_m[idx][w] <= dirty_in;
    end
  end

  // ---------------- physical memory model: fixed-latency response ----------
  int mem_cnt = 0;
  always @(posedge clk) begin
    if ((pmem_read || pmem_write) && !pmem_resp) begin
      if (mem_cnt == MEM_LAT - 1) begin
        pmem_resp <= 1'b1;
        mem_cnt   <= 0;
      end else begin
        mem_cnt <= mem_cnt + 1;
      end
    end else begin
      pmem_resp <= 1'b0;
      mem_cnt   <= 0;
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    string      name;
    int         lat;
    bit         wb;
    bit         alloc;
    logic [3:0] fill;
    logic [3:0] web;
    logic       wmask;
    logic [3:0] dload;
    logic       din;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    assert (obs === exp) else begin
      n_mismatched++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input string name, input int lat, input bit wb, input bit alloc,
                              input logic [3:0] fill, input logic [3:0] web, input logic wmask,
                              input logic [3:0] dload, input logic din);
    exp_t e;
    e.name = name; e.lat = lat; e.wb = wb; e.alloc = alloc; e.fill = fill;
    e.web = web; e.wmask = wmask; e.dload = dload; e.din = din;
    return e;
  endfunction

  task automatic finish_now();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $fatal(1, "run stopped early");
  endtask

  // Called at posedge+1 with the DUT in IDLE; returns at posedge+1 in IDLE.
  task automatic do_txn(input logic rd, input logic wr, input logic [31:0] addr, input exp_t e);
    int cyc;
    bit saw_wb, saw_alloc, sel_bad, order_bad, fill_bad, done;
    logic [3:0] fill, r_web, r_dload;
    logic r_wmask, r_din;
    exp_t x;
    cyc = 0; saw_wb = 0; saw_alloc = 0; sel_bad = 0; order_bad = 0; fill_bad = 0; done = 0;
    fill = '0; r_web = '0; r_dload = '0; r_wmask = 1'b0; r_din = 1'b0;
    sb.push_back(e);
    mem_address = addr;
    mem_read    = rd;
    mem_write   = wr;
    while (!done) begin
      @(negedge clk);
      cyc++;
      if (pmem_write) begin
        saw_wb = 1;
        if (pmem_addr_sel !== PMEM_SEL_VICTIM) sel_bad = 1;
        if (saw_alloc) order_bad = 1;
      end
      if (pmem_read) begin
        saw_alloc = 1;
        if (pmem_addr_sel !== PMEM_SEL_CPU) sel_bad = 1;
      end
      if (valid_load != 4'b0) begin
        fill |= valid_load;
        if (data_web !== ~valid_load || wmask_sel !== 1'b0 || dirty_in !== 1'b0 ||
            tag_load !== valid_load || dirty_load !== valid_load) fill_bad = 1;
      end
      if (mem_resp === 1'b1) begin
        done = 1;
        r_web = data_web; r_wmask = wmask_sel; r_dload = dirty_load; r_din = dirty_in;
      end else if (cyc >= TXN_BUDGET) begin
        check({e.name, "_timeout"}, 32'(mem_resp), 32'd1);
        finish_now();
      end
    end
    x = sb.pop_front();
    $display("txn %s addr=%08h rd=%0b wr=%0b lat=%0d wb=%0b alloc=%0b fill=%b web=%b dload=%b",
             x.name, addr, rd, wr, cyc, saw_wb, saw_alloc, fill, r_web, r_dload);
    check({x.name, "_lat"},       32'(cyc),       32'(x.lat));
    check({x.name, "_wb"},        32'(saw_wb),    32'(x.wb));
    check({x.name, "_alloc"},     32'(saw_alloc), 32'(x.alloc));
    check({x.name, "_fill"},      32'(fill),      32'(x.fill));
    check({x.name, "_fill_strb"}, 32'(fill_bad),  32'd0);
    check({x.name, "_addr_sel"},  32'(sel_bad),   32'd0);
    check({x.name, "_order"},     32'(order_bad), 32'd0);
    check({x.name, "_resp_web"},  32'(r_web),     32'(x.web));
    check({x.name, "_resp_wmsk"}, 32'(r_wmask),   32'(x.wmask));
    check({x.name, "_resp_dld"},  32'(r_dload),   32'(x.dload));
    check({x.name, "_resp_din"},  32'(r_din),     32'(x.din));
    @(posedge clk);
    #1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  initial begin
    int  cyc;
    bit  vl_seen;
    rst = 1'b1;
    mem_read = 1'b0;
    mem_write = 1'b0;
    mem_address = 32'h0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_state",    32'(dut.state_reg), 32'(IDLE));
    check("rst_mem_resp", 32'(mem_resp),      32'd0);
    check("rst_pmem_rd",  32'(pmem_read),     32'd0);
    check("rst_pmem_wr",  32'(pmem_write),    32'd0);
    check("rst_data_web", 32'(data_web),      32'hF);
    check("rst_loads",    32'({tag_load, valid_load, dirty_load}), 32'd0);
    check("rst_victim",   32'(victim_way),    32'd0);
    check("rst_plru_s2",  32'(dut.plru_inst.plru_reg[2]), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Cold read: clean victim way 0, allocate, reread, hit
    do_txn(1, 0, 32'h0000_0040, mk("cold_rd", 8, 0, 1, 4'b0001, 4'hF, 0, 4'b0000, 0));
    check("plru_s2_cold", 32'(dut.plru_inst.plru_reg[2]), 32'b110);

    // Repeat read: two-cycle hit, no memory traffic
    do_txn(1, 0, 32'h0000_0040, mk("hit_rd", 2, 0, 0, 4'b0000, 4'hF, 0, 4'b0000, 0));

    // Write hit on way 0
    do_txn(0, 1, 32'h0000_0044, mk("hit_wr", 2, 0, 0, 4'b0000, 4'b1110, 1, 4'b0001, 1));
    check("plru_s2_wr", 32'(dut.plru_inst.plru_reg[2]), 32'b110);

    // Fill remaining ways of set 2 in PLRU order: 2, 1, 3
    do_txn(1, 0, 32'h0000_0240, mk("fill_t1", 8, 0, 1, 4'b0100, 4'hF, 0, 4'b0000, 0));
    check("plru_s2_t1", 32'(dut.plru_inst.plru_reg[2]), 32'b011);
    do_txn(1, 0, 32'h0000_0440, mk("fill_t2", 8, 0, 1, 4'b0010, 4'hF, 0, 4'b0000, 0));
    check("plru_s2_t2", 32'(dut.plru_inst.plru_reg[2]), 32'b101);
    do_txn(1, 0, 32'h0000_0640, mk("fill_t3", 8, 0, 1, 4'b1000, 4'hF, 0, 4'b0000, 0));
    check("plru_s2_t3", 32'(dut.plru_inst.plru_reg[2]), 32'b000);

    // Fifth tag: victim way 0 is dirty -> writeback then allocate
    do_txn(1, 0, 32'h0000_0840, mk("evict_t4", 12, 1, 1, 4'b0001, 4'hF, 0, 4'b0000, 0));
    check("plru_s2_t4", 32'(dut.plru_inst.plru_reg[2]), 32'b110);
    check("dirty_cleared", 32'(dirty_m[2][0]), 32'd0);

    // Read and write together on a hit (tag 1 in way 2) -> write path
    do_txn(1, 1, 32'h0000_0248, mk("rdwr_hit", 2, 0, 0, 4'b0000, 4'b1011, 1, 4'b0100, 1));
    check("plru_s2_rw", 32'(dut.plru_inst.plru_reg[2]), 32'b011);

    // Reset while allocating: everything drops at once, nothing is filled
    mem_address = 32'h0000_0A40;
    mem_read    = 1'b1;
    cyc = 0;
    vl_seen = 0;
    while (pmem_read !== 1'b1 && cyc < TXN_BUDGET) begin
      @(negedge clk);
      cyc++;
      if (valid_load != 4'b0) vl_seen = 1;
    end
    check("abort_got_pmem_rd", 32'(pmem_read), 32'd1);
    if (pmem_read !== 1'b1) finish_now();
    rst = 1'b1;
    #1;
    check("abort_pmem_rd",  32'(pmem_read),      32'd0);
    check("abort_state",    32'(dut.state_reg),  32'(IDLE));
    check("abort_data_web", 32'(data_web),       32'hF);
    check("abort_loads",    32'({tag_load, valid_load, dirty_load}), 32'd0);
    check("abort_plru_s2",  32'(dut.plru_inst.plru_reg[2]), 32'd0);
    mem_read = 1'b0;
    @(negedge clk);
    if (valid_load != 4'b0) vl_seen = 1;
    check("abort_no_fill",  32'(vl_seen), 32'd0);
    check("abort_not_hit",  32'(way_hit), 32'd0);
    $display("txn abort_alloc addr=%08h reset while pmem_read high", mem_address);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Independent set after reset
    do_txn(1, 0, 32'h0000_0060, mk("cold_s3", 8, 0, 1, 4'b0001, 4'hF, 0, 4'b0000, 0));
    check("plru_s3", 32'(dut.plru_inst.plru_reg[3]), 32'b110);
    check("plru_s2_untouched", 32'(dut.plru_inst.plru_reg[2]), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
